// File: rtl/seq_addsub_flags.sv
// Multi-cycle adder/subtractor producing N/Z/C/V flags, CHUNK bits per clock with a registered inter-chunk carry.
// Optional signed-overflow saturation and the sat port are enabled by defining SEQ_ADDSUB_SAT_EN.
//
// state  | meaning
// IDLE   | in_ready=1, waiting for operands
// RUN    | one chunk of the sum computed per cycle
// DONE   | out_valid=1, result held until out_ready
module seq_addsub_flags #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
`ifdef SEQ_ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("seq_addsub_flags: WIDTH must be at least 2");
        end
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_addsub_flags: CHUNK must divide WIDTH");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [KW-1:0]    r_k;
    logic             r_zacc;
    logic [WIDTH-1:0] r_s;
    logic             r_n;
    logic             r_z;
    logic             r_c;
    logic             r_v;
    logic             w_sat_q;

    logic             w_accept;
    logic             w_last;
    int               w_base;
    logic [CHUNK-1:0] w_a_ch;
    logic [CHUNK-1:0] w_b_ch;
    logic [CHUNK:0]   w_ch_sum;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_v;
    logic             w_z;
    logic             w_clamp;
    logic [WIDTH-1:0] w_s_final;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign s = r_s;
    assign n = r_n;
    assign z = r_z;
    assign c = r_c;
    assign v = r_v;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_k == K_LAST);

    always_comb begin
        w_base   = int'(r_k) * CHUNK;
        w_a_ch   = r_a[w_base +: CHUNK];
        w_b_ch   = r_b[w_base +: CHUNK];
        w_ch_sum = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_carry};
    end

    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[w_base +: CHUNK] = w_ch_sum[CHUNK-1:0];
    end

    assign w_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);
    assign w_z = r_zacc && (w_ch_sum[CHUNK-1:0] == '0);

    // A clamped result is never zero, so z drops whenever clamping occurs.
    assign w_clamp   = w_sat_q && w_v;
    assign w_s_final = w_clamp ? (r_a[WIDTH-1] ? SAT_NEG : SAT_POS) : w_sum_next;

`ifdef SEQ_ADDSUB_SAT_EN
    logic r_sat;
    assign w_sat_q = r_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_sat <= sat;
        end
    end
`else
    assign w_sat_q = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_zacc  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= c_in;
                        r_k     <= '0;
                        r_zacc  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_ch_sum[CHUNK];
                    r_zacc  <= w_z;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result registers only change on the final RUN edge, so they stay frozen in DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s <= '0;
            r_n <= 1'b0;
            r_z <= 1'b0;
            r_c <= 1'b0;
            r_v <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_s <= w_s_final;
            r_n <= w_s_final[WIDTH-1];
            r_z <= w_z && !w_clamp;
            r_c <= w_ch_sum[CHUNK];
            r_v <= w_v;
        end
    end

endmodule

// File: tb/tb_seq_addsub_flags.sv
// Directed, table-driven bench for seq_addsub_flags (WIDTH=32, CHUNK=8).
// Saturation vectors are applied only when SEQ_ADDSUB_SAT_EN is defined.
module tb_seq_addsub_flags;

    localparam int NCH = 4;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic        sat;
        logic [31:0] s;
        logic [3:0]  nzcv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        c_in = 1'b0;
    logic        sat = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] s;
    logic        n, z, c, v;

    int passed = 0;
    int total  = 0;

    vec_t vecs[11];
    vec_t svecs[2];

    seq_addsub_flags #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
`ifdef SEQ_ADDSUB_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one operation and waits for out_valid; returns edges from accept to out_valid.
    task automatic apply(input logic [31:0] ta, input logic [31:0] tb_, input logic tsub,
                         input logic tcin, input logic tsat, output int lat);
        int g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        a = ta; b = tb_; sub = tsub; c_in = tcin; sat = tsat;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " release"}, {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    endtask

    task automatic run_vec(input vec_t tv);
        int lat;
        apply(tv.a, tv.b, tv.sub, tv.cin, tv.sat, lat);
        chk({tv.name, " lat"}, 64'(lat), 64'(NCH));
        chk({tv.name, " s"}, {32'd0, s}, {32'd0, tv.s});
        chk({tv.name, " nzcv"}, {60'd0, n, z, c, v}, {60'd0, tv.nzcv});
        release_out(tv.name);
    endtask

    initial begin
        int lat;
        int hits;
        int first_hit;
        int second_hit;
        logic [31:0] hit_s;

        //          name         a             b             sub   cin   sat   s             nzcv
        vecs[0]  = '{"wrap0",    32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b0110};
        vecs[1]  = '{"ovf_pos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 4'b1001};
        vecs[2]  = '{"5m7",      32'd5,         32'd7,         1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 4'b1000};
        vecs[3]  = '{"7m5",      32'd7,         32'd5,         1'b1, 1'b1, 1'b0, 32'h0000_0002, 4'b0010};
        vecs[4]  = '{"add1234",  32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h2345_6789, 4'b0000};
        vecs[5]  = '{"ovf_neg",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b0111};
        vecs[6]  = '{"sbc",      32'd5,         32'd5,         1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1000};
        vecs[7]  = '{"adc",      32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'b0110};
        vecs[8]  = '{"min_m1",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 4'b0011};
        vecs[9]  = '{"chunk_cy", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0000};
        vecs[10] = '{"zero",     32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b0100};

        svecs[0] = '{"sat_pos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0001};
        svecs[1] = '{"sat_neg",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 4'b1011};

        #12;
        chk("reset", {24'd0, in_ready, out_valid, n, z, c, v, s},
                     {24'd0, 1'b1, 1'b0, 4'b0000, 32'd0});
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end
`ifdef SEQ_ADDSUB_SAT_EN
        for (int i = 0; i < 2; i++) begin
            run_vec(svecs[i]);
        end
`endif

        // Backpressure: DONE held with in_valid pulsing.
        apply(32'd5, 32'd3, 1'b0, 1'b0, 1'b0, lat);
        chk("bp lat", 64'(lat), 64'(NCH));
        for (int i = 0; i < 10; i++) begin
            a = 32'hDEAD_0000 + 32'(i);
            b = 32'h0000_1111;
            in_valid = (i % 2) == 0;
            @(posedge clk); #1;
            chk("bp hold", {26'd0, out_valid, in_ready, n, z, c, v, s},
                           {26'd0, 1'b1, 1'b0, 4'b0000, 32'd8});
        end
        in_valid = 1'b0;
        release_out("bp");
        run_vec('{"after_bp", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h0000_0030, 4'b0000});

        // Reset while chunk 2 is about to be computed.
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0; c_in = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst midrun", {24'd0, in_ready, out_valid, n, z, c, v, s},
                          {24'd0, 1'b1, 1'b0, 4'b0000, 32'd0});
        #2;
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        chk("rst no out_valid", 64'(hits), 64'd0);
        run_vec('{"post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h2345_6789, 4'b0000});

        // Back-to-back with out_ready held high: one op per NCH+2 cycles, DONE lasts one cycle.
        out_ready = 1'b1;
        a = 32'h0000_0003; b = 32'h0000_0004; sub = 1'b0; c_in = 1'b0;
        in_valid = 1'b1;
        hits = 0; first_hit = -1; second_hit = -1; hit_s = '0;
        for (int e = 1; e <= 18; e++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                hits++;
                if (first_hit < 0) begin
                    first_hit = e;
                    hit_s = s;
                end else if (second_hit < 0) begin
                    second_hit = e;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b count", 64'(hits), 64'd3);
        chk("b2b first", 64'(first_hit), 64'(1 + NCH));
        chk("b2b period", 64'(second_hit - first_hit), 64'(NCH + 2));
        chk("b2b s", {32'd0, hit_s}, {32'd0, 32'd7});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
